// File: rtl/operand_feeder_if.sv
// Calculator data-entry bus: the operand feeder is the master, the calculator the slave.
interface operand_feeder_if;
    logic [3:0] Dados;
    logic       Ins;
    logic       Fim;
    logic [4:0] SaidaC;

    modport master (output Dados, output Ins, input Fim, input SaidaC);
    modport slave  (input Dados, input Ins, output Fim, output SaidaC);
endinterface

// File: rtl/operand_feeder.sv
// Drives an operand pair onto the calculator bus with fixed hold times, waits for Fim,
// and scores the returned SaidaC against a locally computed expected result.
module operand_feeder #(
    parameter int HOLD_A  = 1,
    parameter int HOLD_B  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Start,
    input  logic [3:0]             OpA,
    input  logic [3:0]             OpB,
    input  logic                   OpSel,
    operand_feeder_if.master       bus,
    output logic                   Busy,
    output logic                   Done,
    output logic [4:0]             Result,
    output logic                   Match,
    output logic                   TimedOut,
    output logic [9:0]             OkCount,
    output logic [9:0]             ErrCount
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] LAST_A    = CNT_W'(HOLD_A - 1);
    localparam logic [CNT_W-1:0] LAST_B    = CNT_W'(HOLD_B - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic [3:0]       dados_q;
    logic             ins_q;
    logic [4:0]       exp_res;
    logic             res_ok;

    // Reference result is formed in 6 signed bits so 2A-B can go negative, then wraps mod 32.
    function automatic logic [4:0] expected_result(input logic [3:0] a,
                                                   input logic [3:0] b,
                                                   input logic       sel);
        logic signed [5:0] sa;
        logic signed [5:0] sb;
        logic signed [5:0] r;
        sa = signed'({2'b00, a});
        sb = signed'({2'b00, b});
        if (sel) r = (sa <<< 1) - sb;
        else     r = (sa + sb) >>> 1;
        return r[4:0];
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] c);
        return (c == 10'h3FF) ? c : c + 10'd1;
    endfunction

    assign exp_res   = expected_result(a_q, b_q, ins_q);
    assign res_ok    = (bus.SaidaC == exp_res);
    assign bus.Dados = dados_q;
    assign bus.Ins   = ins_q;

    // Operand latches carry data only, so they are loaded on acceptance and never reset.
    always_ff @(posedge Clk) begin
        if (state == S_IDLE && Start) begin
            a_q <= OpA;
            b_q <= OpB;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            dados_q  <= '0;
            ins_q    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
            Match    <= 1'b0;
            TimedOut <= 1'b0;
            OkCount  <= '0;
            ErrCount <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    dados_q <= '0;
                    Busy    <= 1'b0;
                    if (Start) begin
                        dados_q <= OpA;
                        ins_q   <= OpSel;
                        Busy    <= 1'b1;
                        cnt     <= '0;
                        state   <= S_SEND_A;
                    end
                end
                S_SEND_A: begin
                    if (cnt == LAST_A) begin
                        dados_q <= b_q;
                        cnt     <= '0;
                        state   <= S_SEND_B;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SEND_B: begin
                    if (cnt == LAST_B) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // Fim is checked before the timeout so a same-cycle Fim counts as a completion.
                    if (bus.Fim) begin
                        Result   <= bus.SaidaC;
                        Match    <= res_ok;
                        TimedOut <= 1'b0;
                        if (res_ok) OkCount  <= sat_inc(OkCount);
                        else        ErrCount <= sat_inc(ErrCount);
                        Done    <= 1'b1;
                        Busy    <= 1'b0;
                        dados_q <= '0;
                        state   <= S_IDLE;
                    end else if (cnt == LAST_WAIT) begin
                        TimedOut <= 1'b1;
                        Match    <= 1'b0;
                        ErrCount <= sat_inc(ErrCount);
                        Done     <= 1'b1;
                        Busy     <= 1'b0;
                        dados_q  <= '0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: a timing-level reference model is compared every cycle,
// with directed transactions pinning literal results and random traffic afterwards.
module tb_operand_feeder;
    localparam int HA = 1;
    localparam int HB = 4;
    localparam int TO = 15;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Start = 1'b0;
    logic       OpSel = 1'b0;
    logic [3:0] OpA = '0;
    logic [3:0] OpB = '0;
    logic       Busy;
    logic       Done;
    logic [4:0] Result;
    logic       Match;
    logic       TimedOut;
    logic [9:0] OkCount;
    logic [9:0] ErrCount;

    operand_feeder_if bus();

    operand_feeder #(.HOLD_A(HA), .HOLD_B(HB), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .OpA(OpA), .OpB(OpB), .OpSel(OpSel),
        .bus(bus), .Busy(Busy), .Done(Done), .Result(Result), .Match(Match),
        .TimedOut(TimedOut), .OkCount(OkCount), .ErrCount(ErrCount)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int exp_of(input int a, input int b, input int sel);
        int v;
        v = sel ? (2 * a - b) : ((a + b) / 2);
        return v & 31;
    endfunction

    // Reference model: a transaction is described by its start edge and operands;
    // outputs follow from how many edges have elapsed since that start.
    int e = 0;
    int m_k = 0;
    int m_a = 0, m_b = 0, m_sel = 0, m_exp = 0;
    bit m_active = 0;
    int m_dados = 0, m_ins = 0, m_busy = 0, m_done = 0;
    int m_result = 0, m_match = 0, m_to = 0, m_ok = 0, m_err = 0;

    always @(posedge Clk) begin
        int age;
        e++;
        if (Rst) begin
            m_active = 0; m_dados = 0; m_ins = 0; m_busy = 0; m_done = 0;
            m_result = 0; m_match = 0; m_to = 0; m_ok = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (Start) begin
                    m_active = 1; m_k = e;
                    m_a = OpA; m_b = OpB; m_sel = OpSel; m_ins = OpSel;
                    m_exp = exp_of(m_a, m_b, m_sel);
                    m_dados = m_a; m_busy = 1;
                end else begin
                    m_dados = 0; m_busy = 0;
                end
            end else begin
                age = e - m_k;
                if (age >= HA + HB + 1 && bus.Fim) begin
                    m_result = bus.SaidaC;
                    m_match = (m_result == m_exp);
                    m_to = 0;
                    if (m_match != 0) m_ok = (m_ok < 1023) ? m_ok + 1 : 1023;
                    else              m_err = (m_err < 1023) ? m_err + 1 : 1023;
                    m_active = 0; m_done = 1; m_busy = 0; m_dados = 0;
                end else if (age == HA + HB + TO) begin
                    m_to = 1; m_match = 0;
                    m_err = (m_err < 1023) ? m_err + 1 : 1023;
                    m_active = 0; m_done = 1; m_busy = 0; m_dados = 0;
                end else begin
                    m_dados = (age < HA) ? m_a : m_b;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("Dados", bus.Dados, m_dados);
            chk("Ins", bus.Ins, m_ins);
            chk("Busy", Busy, m_busy);
            chk("Done", Done, m_done);
            chk("Result", Result, m_result);
            chk("Match", Match, m_match);
            chk("TimedOut", TimedOut, m_to);
            chk("OkCount", OkCount, m_ok);
            chk("ErrCount", ErrCount, m_err);
        end
    end

    // mode 0: single Start pulse; 1: extra Start pulses at idx 3 and 7; 2: Start held high.
    task automatic run_txn(input int a, input int b, input int sel, input int f1, input int f2,
                           input int sc, input int mode, output int lat);
        int idx;
        OpA = 4'(a); OpB = 4'(b); OpSel = sel[0]; Start = 1'b1;
        @(negedge Clk);
        idx = 0;
        if (mode != 2) Start = 1'b0;
        chk("start_busy", Busy, 1);
        chk("start_dados_a", bus.Dados, a);
        chk("start_ins", bus.Ins, sel);
        while (!Done && idx < 100) begin
            if (idx == HA) chk("dados_b", bus.Dados, b);
            bus.Fim = (idx == f1 || idx == f2);
            bus.SaidaC = 5'(sc);
            if (mode == 1) Start = (idx == 3 || idx == 7);
            @(negedge Clk);
            idx++;
        end
        bus.Fim = 1'b0;
        if (mode != 2) Start = 1'b0;
        chk("done_seen", Done, 1);
        lat = idx;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.Fim = 1'b0;
        bus.SaidaC = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", Busy, 0);
        chk("rst_dados", bus.Dados, 0);
        chk("rst_ok", OkCount, 0);
        chk("rst_err", ErrCount, 0);
        repeat (2) @(negedge Clk);

        // Average 15,14 with Fim two cycles into WAIT.
        run_txn(15, 14, 0, 6, -1, 14, 0, lat);
        chk("avg_lat", lat, 7);
        chk("avg_result", Result, 14);
        chk("avg_match", Match, 1);
        chk("avg_ok", OkCount, 1);
        @(negedge Clk);
        chk("avg_done_once", Done, 0);

        run_txn(3, 9, 1, 5, -1, 29, 0, lat);
        chk("wrap_lat", lat, 6);
        chk("wrap_match", Match, 1);
        run_txn(15, 0, 1, 5, -1, 30, 0, lat);
        chk("wrap2_match", Match, 1);
        run_txn(15, 0, 1, 5, -1, 31, 0, lat);
        chk("bad_match", Match, 0);
        chk("bad_err", ErrCount, 1);
        chk("bad_result", Result, 31);

        // Timeout with Fim low.
        run_txn(6, 2, 0, -1, -1, 0, 0, lat);
        chk("to_lat", lat, HA + HB + TO);
        chk("to_flag", TimedOut, 1);
        chk("to_result_kept", Result, 31);
        chk("to_err", ErrCount, 2);

        // Start pulsed in SEND_B and WAIT is ignored.
        run_txn(5, 6, 0, 9, -1, 5, 1, lat);
        chk("ign_lat", lat, 10);
        chk("ign_ok", OkCount, 4);
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            chk("ign_no_extra_done", Done, 0);
            chk("ign_idle", Busy, 0);
        end

        // Start held through Done: the next transaction starts on the Done cycle.
        run_txn(2, 1, 1, 5, -1, 3, 2, lat);
        chk("hold_lat", lat, 6);
        run_txn(7, 8, 0, 5, -1, 7, 0, lat);
        chk("b2b_lat", lat, 6);
        chk("b2b_ok", OkCount, 6);

        // Early Fim in SEND_B ignored, later WAIT Fim completes.
        run_txn(9, 9, 0, 2, 8, 9, 0, lat);
        chk("early_lat", lat, 9);
        chk("early_ok", OkCount, 7);

        // Fim on the timeout cycle counts as completion.
        run_txn(1, 4, 1, HA + HB + TO - 1, -1, 30, 0, lat);
        chk("simul_lat", lat, HA + HB + TO);
        chk("simul_to", TimedOut, 0);
        chk("simul_match", Match, 1);
        chk("simul_ok", OkCount, 8);

        // Reset in the middle of WAIT, with a Fim in flight.
        OpA = 4'd4; OpB = 4'd2; OpSel = 1'b0; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (6) @(negedge Clk);
        bus.Fim = 1'b1; bus.SaidaC = 5'd3; Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0; bus.Fim = 1'b0;
        chk("rstw_busy", Busy, 0);
        chk("rstw_dados", bus.Dados, 0);
        chk("rstw_ok", OkCount, 0);
        chk("rstw_err", ErrCount, 0);
        chk("rstw_done", Done, 0);
        @(negedge Clk);
        run_txn(15, 15, 0, 5, -1, 15, 0, lat);
        chk("post_rst_lat", lat, 6);
        chk("post_rst_ok", OkCount, 1);

        // Back-to-back matching transactions until OkCount saturates.
        for (int i = 0; i < 1100 * 7; i++) begin
            Start = 1'b1;
            OpA = 4'($urandom); OpB = 4'($urandom); OpSel = 1'($urandom);
            bus.Fim = 1'b1;
            bus.SaidaC = 5'(m_exp);
            @(negedge Clk);
        end
        Start = 1'b0; bus.Fim = 1'b0;
        repeat (25) @(negedge Clk);
        chk("sat_ok", OkCount, 1023);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            Rst = ($urandom_range(0, 199) == 0);
            Start = ($urandom_range(0, 2) == 0);
            OpA = 4'($urandom); OpB = 4'($urandom); OpSel = 1'($urandom);
            bus.Fim = (i < 2000) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
            bus.SaidaC = $urandom_range(0, 1) ? 5'(m_exp) : 5'($urandom);
            @(negedge Clk);
        end
        Rst = 1'b0; Start = 1'b0; bus.Fim = 1'b0;
        repeat (25) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_feeder.md
# operand_feeder

Initiator side of the calculator data-entry protocol. Accepts an operand pair and an operation code from a host. Drives them onto the calculator's 4-bit `Dados` bus with fixed hold times, then waits for `Fim`. On `Fim` it captures `SaidaC` and checks it against a locally computed expected result. It sits between a host/sequencer and the calculator top level, replacing hand-driven stimulus, and keeps running pass/fail counts.

## Interface
Parameters:
- `HOLD_A`, default 1: cycles operand A is held on `Dados` (≥1).
- `HOLD_B`, default 4: cycles operand B is held on `Dados` before waiting (≥1).
- `TIMEOUT`, default 15: cycles to wait for `Fim` before giving up (≥1).

Ports:
- `Clk` in, 1: single clock, rising-edge.
- `Rst` in, 1: synchronous, active-high reset.
- `Start` in, 1: request a transaction; sampled only in IDLE.
- `OpA` in, 4: operand A.
- `OpB` in, 4: operand B.
- `OpSel` in, 1: 0 = average (A+B)/2, 1 = 2A−B.
- `Dados` out, 4: calculator data bus.
- `Ins` out, 1: operation select to the calculator.
- `Fim` in, 1: calculator done.
- `SaidaC` in, 5: calculator result.
- `Busy` out, 1: transaction in progress.
- `Done` out, 1: one-cycle completion pulse.
- `Result` out, 5: last captured `SaidaC`.
- `Match` out, 1: last `Result` equals expected (valid with/after `Done`).
- `TimedOut` out, 1: last transaction ended without `Fim`.
- `OkCount` out, 10: matching transactions.
- `ErrCount` out, 10: mismatching or timed-out transactions.

## Operation
- Reset values: state IDLE, `Dados`=0, `Ins`=0, `Busy`=0, `Done`=0, `Result`=0, `Match`=0, `TimedOut`=0, both counts 0.
- States:
  - **IDLE**
    - `Dados`=0, `Busy`=0.
    - On `Start`=1: latch `OpA`, `OpB` and `OpSel`, then go to SEND_A.
  - **SEND_A**
    - `Dados`=A and `Ins`=latched `OpSel` for `HOLD_A` cycles, then go to SEND_B.
  - **SEND_B**
    - `Dados`=B for `HOLD_B` cycles, then go to WAIT.
  - **WAIT**
    - `Dados` stays at B. A cycle counter counts up from 0.
    - On `Fim`=1:
      - `Result`←`SaidaC`.
      - `Match`←(`SaidaC`==expected), `TimedOut`←0.
      - Increment `OkCount` or `ErrCount`.
      - `Done` pulse; go to IDLE.
    - When the counter reaches `TIMEOUT` with no `Fim`:
      - `TimedOut`←1, `Match`←0, `Result` unchanged.
      - `ErrCount`+1.
      - `Done` pulse; go to IDLE.
- `Ins` holds the latched `OpSel` from SEND_A until the next accepted `Start`.
- Expected result:
  - Computed in 6 bits from the latched operands: `OpSel`=0 → (A+B)>>1, truncated toward zero; `OpSel`=1 → 2A−B.
  - Take the low 5 bits, i.e. modulo 32. Example: A=3, B=9 → 29.
- Counters saturate at 1023.
- `Start` outside IDLE is ignored; it is not queued.
- `Fim` during SEND_A or SEND_B is ignored.
- If `Fim` is seen on the same cycle the timeout count is reached, `Fim` wins.

## Timing
- `Start` sampled at edge k:
  - `Busy`=1 and `Dados`=A after edge k.
  - `Dados`=B after edge k+`HOLD_A`.
  - WAIT is entered after edge k+`HOLD_A`+`HOLD_B`.
- `Fim` is registered-sampled in WAIT. If `Fim` is high at edge m, then after edge m: `Done`=1, `Busy`=0, and `Result`, `Match` and the counts are updated.
- Minimum `Start`→`Done` latency is `HOLD_A`+`HOLD_B`+1 edges (6 with defaults). Timeout latency is `HOLD_A`+`HOLD_B`+`TIMEOUT` edges.
- `Done` is high for exactly one cycle, which is the first IDLE cycle. A `Start` on that cycle is accepted, so transactions can run back-to-back.
- `Rst` mid-transaction: at the next edge all outputs return to reset values, including counts. An in-flight `Fim` is discarded.

## Test plan
- Average, `OpSel`=0, A=15, B=14; model returns `Fim` with `SaidaC`=14 two cycles into WAIT → `Done` once, `Result`=14, `Match`=1, `OkCount`=1; `Dados` shows 15 for 1 cycle, then 14.
- 2A−B wrap, `OpSel`=1, A=3, B=9, `SaidaC`=29 → `Match`=1; with A=15, B=0, `SaidaC`=30 → `Match`=1; with `SaidaC`=31 → `Match`=0, `ErrCount`+1.
- Timeout: `Fim` held low → `Done` exactly 20 edges after `Start` (defaults), `TimedOut`=1, `Result` keeps its previous value, `ErrCount`+1.
- `Start` pulsed during SEND_B and again during WAIT → ignored, with exactly one `Done`. `Start` held through the `Done` cycle → second transaction begins immediately.
- Early `Fim` during SEND_A/SEND_B then low → no capture; transaction completes on a later WAIT `Fim`. Simultaneous `Fim` and timeout cycle → counted as a completion, `TimedOut`=0.
- `Rst` asserted for 1 cycle in the middle of WAIT → next cycle `Busy`=0, `Dados`=0, counts 0. The following `Start` runs normally.
